// File: rtl/systolic_deskew_out.sv
// Realigns skewed MAC-array column results into whole rows
// and streams them out on a valid/ready interface.
module systolic_deskew_out #(
  parameter  int MAC_WIDTH  = 8,
  parameter  int ACC_WIDTH  = 32,
  parameter  int ROWS       = MAC_WIDTH,
  parameter  int FIFO_DEPTH = 2*MAC_WIDTH,
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic [MAC_WIDTH*ACC_WIDTH-1:0] col_data_in,
  input  logic [MAC_WIDTH-1:0]           col_valid_in,
  output logic [MAC_WIDTH*ACC_WIDTH-1:0] row_data_out,
  output logic                           row_valid,
  input  logic                           row_ready,
  output logic [IW-1:0]                  row_index,
  output logic                           row_last,
  output logic                           tile_done,
  output logic                           overflow,
  output logic                           busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ACC_WIDTH-1:0] mem [MAC_WIDTH][FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr [MAC_WIDTH];
  logic [PW-1:0]        rd_ptr [MAC_WIDTH];
  logic [CW-1:0]        count [MAC_WIDTH];

  logic [MAC_WIDTH-1:0] nonempty;
  logic [MAC_WIDTH-1:0] full;
  logic [MAC_WIDTH-1:0] push;
  logic [MAC_WIDTH-1:0] drop;
  logic                 load;
  logic                 accept;
  logic                 at_last;

  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int c = 0; c < MAC_WIDTH; c++) begin
      nonempty[c] = (count[c] != '0);
      full[c]     = (count[c] == CW'(FIFO_DEPTH));
    end
  end

  assign load    = (&nonempty) && (!row_valid || row_ready);
  assign accept  = row_valid && row_ready;
  assign at_last = (row_index == IW'(ROWS-1));

  // A full column still takes a push when the same cycle pops it.
  always_comb begin
    push = '0;
    drop = '0;
    for (int c = 0; c < MAC_WIDTH; c++) begin
      push[c] = col_valid_in[c] && (!full[c] || load);
      drop[c] = col_valid_in[c] && full[c] && !load;
    end
  end

  always_comb begin
    busy = row_valid || (|nonempty);
  end

  assign row_last = row_valid && at_last;

  always_ff @(posedge clock) begin
    for (int c = 0; c < MAC_WIDTH; c++) begin
      if (push[c] && !clear)
        mem[c][wr_ptr[c]] <= col_data_in[c*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < MAC_WIDTH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      row_data_out <= '0;
      row_valid    <= 1'b0;
      row_index    <= '0;
      tile_done    <= 1'b0;
      overflow     <= 1'b0;
    end else if (clear) begin
      for (int c = 0; c < MAC_WIDTH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      row_data_out <= '0;
      row_valid    <= 1'b0;
      row_index    <= '0;
      tile_done    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      tile_done <= accept && at_last;
      if (|drop)
        overflow <= 1'b1;
      if (accept)
        row_index <= at_last ? '0 : row_index + 1'b1;
      if (load) begin
        row_valid <= 1'b1;
        for (int c = 0; c < MAC_WIDTH; c++)
          row_data_out[c*ACC_WIDTH +: ACC_WIDTH] <= mem[c][rd_ptr[c]];
      end else if (accept) begin
        row_valid <= 1'b0;
      end
      for (int c = 0; c < MAC_WIDTH; c++) begin
        if (push[c])
          wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (load)
          rd_ptr[c] <= rd_ptr[c] + 1'b1;
        count[c] <= count[c] + CW'(push[c]) - CW'(load);
      end
    end
  end

endmodule

// File: tb/tb_systolic_deskew_out.sv
// Bench for systolic_deskew_out: vector table, corner
// sequences and a queue-based random reference model.
module tb_systolic_deskew_out;

  localparam int MW = 4;
  localparam int AW = 32;
  localparam int RW = 4;
  localparam int FD = 4;
  localparam int DW = MW*AW;

  logic          clock;
  logic          reset;
  logic          clear;
  logic [DW-1:0] col_data_in;
  logic [MW-1:0] col_valid_in;
  logic [DW-1:0] row_data_out;
  logic          row_valid;
  logic          row_ready;
  logic [1:0]    row_index;
  logic          row_last;
  logic          tile_done;
  logic          overflow;
  logic          busy;

  systolic_deskew_out #(
    .MAC_WIDTH(MW), .ACC_WIDTH(AW),
    .ROWS(RW), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .col_data_in(col_data_in),
    .col_valid_in(col_valid_in),
    .row_data_out(row_data_out),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_index(row_index), .row_last(row_last),
    .tile_done(tile_done), .overflow(overflow),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rowval(input int r);
    logic [DW-1:0] d;
    d = '0;
    for (int c = 0; c < MW; c++)
      d[c*AW +: AW] = AW'(16*r + c);
    return d;
  endfunction

  task automatic skew(input int k, input int n,
                      output logic [MW-1:0] v,
                      output logic [DW-1:0] d);
    v = '0;
    d = '0;
    for (int c = 0; c < MW; c++) begin
      if (k - c >= 0 && k - c < n) begin
        v[c] = 1'b1;
        d[c*AW +: AW] = AW'(16*(k-c) + c);
      end
    end
  endtask

  task automatic idle();
    col_valid_in = '0;
    col_data_in  = '0;
    clear        = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  typedef struct {
    logic [MW-1:0] v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [1:0]    e_index;
    logic          e_last;
    logic          e_done;
    logic          e_busy;
  } vec_t;

  vec_t tbl [10];

  task automatic run_table(input string tag);
    for (int k = 0; k < 10; k++) begin
      col_valid_in = tbl[k].v;
      col_data_in  = tbl[k].d;
      row_ready    = tbl[k].rdy;
      tick();
      chk({tag, "_valid"}, DW'(row_valid), DW'(tbl[k].e_valid));
      chk({tag, "_index"}, DW'(row_index), DW'(tbl[k].e_index));
      chk({tag, "_last"}, DW'(row_last), DW'(tbl[k].e_last));
      chk({tag, "_done"}, DW'(tile_done), DW'(tbl[k].e_done));
      chk({tag, "_busy"}, DW'(busy), DW'(tbl[k].e_busy));
      if (tbl[k].e_valid)
        chk({tag, "_data"}, row_data_out, tbl[k].e_data);
    end
    idle();
  endtask

  // Reference model: one unbounded queue per column capped at FD.
  logic [AW-1:0] mq [MW][$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  int            m_index;
  logic          m_done;
  logic          m_ovf;

  task automatic model_reset();
    for (int c = 0; c < MW; c++) mq[c].delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_index = 0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic [MW-1:0] v,
                            input logic [DW-1:0] d,
                            input logic rdy);
    bit ld;
    bit acc;
    ld = 1'b1;
    for (int c = 0; c < MW; c++)
      if (mq[c].size() == 0) ld = 1'b0;
    ld  = ld && (!m_valid || rdy);
    acc = m_valid && rdy;
    m_done = acc && (m_index == RW-1);
    if (acc) m_index = (m_index + 1) % RW;
    if (ld) begin
      for (int c = 0; c < MW; c++)
        m_data[c*AW +: AW] = mq[c].pop_front();
      m_valid = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    for (int c = 0; c < MW; c++) begin
      if (v[c]) begin
        if (mq[c].size() < FD) mq[c].push_back(d[c*AW +: AW]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic model_busy();
    logic b;
    b = m_valid;
    for (int c = 0; c < MW; c++)
      if (mq[c].size() != 0) b = 1'b1;
    return b;
  endfunction

  initial begin
    logic [MW-1:0] v;
    logic [DW-1:0] d;
    int n;

    for (int k = 0; k < 10; k++) begin
      int r;
      skew(k, 4, v, d);
      r = k - 4;
      tbl[k].v       = v;
      tbl[k].d       = d;
      tbl[k].rdy     = 1'b1;
      tbl[k].e_valid = (r >= 0 && r < 4);
      tbl[k].e_data  = tbl[k].e_valid ? rowval(r) : '0;
      tbl[k].e_index = tbl[k].e_valid ? 2'(r) : 2'd0;
      tbl[k].e_last  = (r == 3);
      tbl[k].e_done  = (k == 8);
      tbl[k].e_busy  = (k <= 7);
    end

    reset = 1'b0;
    row_ready = 1'b0;
    idle();
    tick();
    chk("rst_valid", DW'(row_valid), '0);
    chk("rst_data", row_data_out, '0);
    chk("rst_index", DW'(row_index), '0);
    chk("rst_flags", DW'({row_last, tile_done, overflow, busy}), '0);
    reset = 1'b1;
    tick();

    // T1
    run_table("t1");

    // T2: held output under backpressure
    do_clear();
    row_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      skew(k, 4, v, d);
      col_valid_in = v;
      col_data_in  = d;
      tick();
      if (k >= 4) begin
        chk("t2_hold_valid", DW'(row_valid), 1);
        chk("t2_hold_data", row_data_out, rowval(0));
        chk("t2_hold_index", DW'(row_index), 0);
      end
    end
    idle();
    row_ready = 1'b1;
    for (int r = 1; r < 4; r++) begin
      tick();
      chk("t2_drain_valid", DW'(row_valid), 1);
      chk("t2_drain_data", row_data_out, rowval(r));
      chk("t2_drain_index", DW'(row_index), DW'(r));
    end
    tick();
    chk("t2_end_valid", DW'(row_valid), 0);
    chk("t2_end_done", DW'(tile_done), 1);
    chk("t2_ovf", DW'(overflow), 0);

    // T3: overflow with FD=4 and six skewed rows
    do_clear();
    row_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      skew(k, 6, v, d);
      col_valid_in = v;
      col_data_in  = d;
      tick();
      if (k == 4) chk("t3_ovf_early", DW'(overflow), 0);
    end
    idle();
    chk("t3_ovf_set", DW'(overflow), 1);
    row_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (row_valid) begin
        chk("t3_row_data", row_data_out, rowval(n));
        n++;
      end
      tick();
    end
    chk("t3_row_count", DW'(n), 5);
    chk("t3_ovf_sticky", DW'(overflow), 1);
    chk("t3_busy", DW'(busy), 0);

    // T4: full FIFO, push and pop together
    do_clear();
    row_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      col_valid_in = '1;
      col_data_in  = rowval(r);
      tick();
    end
    chk("t4_pre_data", row_data_out, rowval(0));
    chk("t4_pre_ovf", DW'(overflow), 0);
    col_valid_in = '1;
    col_data_in  = rowval(5);
    row_ready    = 1'b1;
    tick();
    idle();
    chk("t4_ovf", DW'(overflow), 0);
    chk("t4_valid", DW'(row_valid), 1);
    chk("t4_data", row_data_out, rowval(1));
    for (int r = 2; r < 6; r++) begin
      tick();
      chk("t4_drain_data", row_data_out, rowval(r));
      chk("t4_drain_valid", DW'(row_valid), 1);
    end
    tick();
    chk("t4_end_valid", DW'(row_valid), 0);
    chk("t4_end_ovf", DW'(overflow), 0);

    // T5: clear mid-tile with pushes in the same cycle
    do_clear();
    row_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      col_valid_in = tbl[k].v;
      col_data_in  = tbl[k].d;
      tick();
    end
    chk("t5_pre_index", DW'(row_index), 2);
    col_valid_in = '1;
    col_data_in  = rowval(9);
    clear = 1'b1;
    tick();
    idle();
    chk("t5_busy", DW'(busy), 0);
    chk("t5_valid", DW'(row_valid), 0);
    chk("t5_index", DW'(row_index), 0);
    chk("t5_ovf", DW'(overflow), 0);
    run_table("t5");

    // T6: asynchronous reset between edges mid-feed
    for (int k = 0; k < 6; k++) begin
      col_valid_in = tbl[k].v;
      col_data_in  = tbl[k].d;
      tick();
    end
    chk("t6_pre_valid", DW'(row_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", DW'(row_valid), 0);
    chk("t6_async_data", row_data_out, '0);
    chk("t6_async_index", DW'(row_index), 0);
    chk("t6_async_busy", DW'(busy), 0);
    idle();
    tick();
    reset = 1'b1;
    tick();
    run_table("t6");

    // Randomized run against the queue model
    do_clear();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      logic rdy;
      logic clr;
      for (int c = 0; c < MW; c++) begin
        v[c] = ($urandom_range(9) < 6);
        d[c*AW +: AW] = $urandom;
      end
      rdy = 1'($urandom_range(1));
      clr = ($urandom_range(29) == 0);
      col_valid_in = v;
      col_data_in  = d;
      row_ready    = rdy;
      clear        = clr;
      if (clr) model_reset();
      else model_step(v, d, rdy);
      tick();
      chk("rnd_valid", DW'(row_valid), DW'(m_valid));
      if (m_valid) chk("rnd_data", row_data_out, m_data);
      chk("rnd_index", DW'(row_index), DW'(m_index));
      chk("rnd_last", DW'(row_last),
          DW'(m_valid && m_index == RW-1));
      chk("rnd_done", DW'(tile_done), DW'(m_done));
      chk("rnd_ovf", DW'(overflow), DW'(m_ovf));
      chk("rnd_busy", DW'(busy), DW'(model_busy()));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
